// File: rtl/norm_sched_80_pkg.sv
// Shared constants and result type for the normalizing scheduler.
// Mantissa/LZC widths are fixed; lane and exponent widths come from the top parameters.
package norm_sched_80_pkg;

   localparam int MANT_W    = 80;
   localparam int LZC_W     = 7;
   localparam int EXP_W_DEF = 16;
   localparam int ZERO_W    = 1;
   localparam int UFLOW_W   = 1;

   typedef struct packed {
      logic [MANT_W-1:0]  mant;
      logic [ZERO_W-1:0]  zero;
      logic [UFLOW_W-1:0] uflow;
   } res_t;

endpackage

// File: rtl/lza_80.sv
// 80-bit leading-zero counter: per-byte priority encoders merged top byte first.
// Output is 80 for an all-zero input.
module lza_80
   import norm_sched_80_pkg::*;
(
   input  logic [MANT_W-1:0] mant,
   output logic [LZC_W-1:0]  lzc
);

   localparam int NB = MANT_W / 8;

   logic [NB-1:0]   byte_nz;
   logic [3*NB-1:0] byte_lz;

   // byte 0 is the most significant byte
   for (genvar gi = 0; gi < NB; gi++) begin : g_byte
      logic [7:0] seg;
      logic [2:0] lz_b;

      assign seg         = mant[MANT_W-1-8*gi -: 8];
      assign byte_nz[gi] = |seg;

      always_comb begin
         lz_b = 3'd0;
         for (int b = 0; b < 8; b++) begin
            if (seg[b]) lz_b = 3'(7 - b);
         end
      end

      assign byte_lz[3*gi +: 3] = lz_b;
   end

   always_comb begin
      lzc = LZC_W'(MANT_W);
      for (int k = NB - 1; k >= 0; k--) begin
         if (byte_nz[k]) lzc = LZC_W'(8 * k) + {4'd0, byte_lz[3*k +: 3]};
      end
   end

endmodule

// File: rtl/norm_sched_80.sv
// Round-robin shared normalizer: S1 arbitrates and registers an operand,
// S2 counts leading zeros, shifts and registers the result.
module norm_sched_80
   import norm_sched_80_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int EXP_W = EXP_W_DEF,
   localparam int LANE_W = $clog2(NREQ)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*MANT_W-1:0]  req_mant,
   input  logic [NREQ*EXP_W-1:0]   req_exp,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANE_W-1:0]       out_lane,
   output logic [MANT_W-1:0]       out_mant,
   output logic [EXP_W-1:0]        out_exp,
   output logic                    out_zero,
   output logic                    out_uflow
);

   logic [MANT_W-1:0] lane_mant [NREQ];
   logic [EXP_W-1:0]  lane_exp  [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane_mant[gi] = req_mant[gi*MANT_W +: MANT_W];
      assign lane_exp[gi]  = req_exp[gi*EXP_W +: EXP_W];
   end

   logic [LANE_W-1:0] ptr_reg, ptr_next;
   logic              s1_valid_reg;
   logic [MANT_W-1:0] s1_mant_reg;
   logic [EXP_W-1:0]  s1_exp_reg;
   logic [LANE_W-1:0] s1_lane_reg;
   logic              out_valid_reg;
   res_t              res_reg, res_next;
   logic [EXP_W-1:0]  out_exp_reg, exp_next;
   logic [LANE_W-1:0] out_lane_reg;

   logic              s1_en, s2_en;
   logic              found;
   logic [LANE_W-1:0] sel;
   logic [NREQ-1:0]   grant;
   logic              grant_any;

   assign s2_en = !out_valid_reg || out_ready;
   assign s1_en = !s1_valid_reg || s2_en;

   function automatic logic [LANE_W-1:0] rr_idx(input logic [LANE_W-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= NREQ) s = s - NREQ;
      return LANE_W'(s);
   endfunction

   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int off = 0; off < NREQ; off++) begin
         if (!found && req_valid[rr_idx(ptr_reg, off)]) begin
            found = 1'b1;
            sel   = rr_idx(ptr_reg, off);
         end
      end
   end

   // reset gates the grant so nothing is accepted in the reset cycle
   always_comb begin
      grant = '0;
      if (found && s1_en && !rst) grant[sel] = 1'b1;
   end

   assign grant_any = |grant;
   assign req_ready = grant;

   always_comb begin
      ptr_next = ptr_reg;
      if (grant_any) ptr_next = (sel == LANE_W'(NREQ - 1)) ? '0 : sel + LANE_W'(1);
   end

   logic [LZC_W-1:0] lzc;
   logic [EXP_W-1:0] lzc_ext;

   lza_80 u_lza (
      .mant (s1_mant_reg),
      .lzc  (lzc)
   );

   assign lzc_ext = EXP_W'(lzc);

   // underflow shifts by exp, which is then below lzc and fits the LZC width
   always_comb begin
      res_next = '0;
      exp_next = '0;
      if (lzc == LZC_W'(MANT_W)) begin
         res_next.zero = 1'b1;
      end else if (lzc_ext <= s1_exp_reg) begin
         res_next.mant = s1_mant_reg << lzc;
         exp_next      = s1_exp_reg - lzc_ext;
      end else begin
         res_next.mant  = s1_mant_reg << s1_exp_reg[LZC_W-1:0];
         res_next.uflow = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg       <= '0;
         s1_valid_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         res_reg       <= '0;
         out_exp_reg   <= '0;
         out_lane_reg  <= '0;
      end else begin
         ptr_reg <= ptr_next;
         if (s1_en) s1_valid_reg <= grant_any;
         if (s2_en) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               res_reg      <= res_next;
               out_exp_reg  <= exp_next;
               out_lane_reg <= s1_lane_reg;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (s1_en && grant_any) begin
         s1_mant_reg <= lane_mant[sel];
         s1_exp_reg  <= lane_exp[sel];
         s1_lane_reg <= sel;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_lane  = out_lane_reg;
   assign out_mant  = res_reg.mant;
   assign out_exp   = out_exp_reg;
   assign out_zero  = res_reg.zero;
   assign out_uflow = res_reg.uflow;

endmodule

// File: tb/tb_norm_sched_80.sv
// Scoreboard bench for norm_sched_80: accepted operands are modelled at acceptance
// and compared in order against each delivered result.
`timescale 1ns/1ps
module tb_norm_sched_80;

   localparam int NREQ  = 4;
   localparam int EXP_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*80-1:0] req_mant;
   logic [NREQ*EXP_W-1:0] req_exp;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out_lane;
   logic [79:0]       out_mant;
   logic [EXP_W-1:0]  out_exp;
   logic              out_zero;
   logic              out_uflow;

   typedef struct {
      logic [1:0]  lane;
      logic [79:0] mant;
      logic [15:0] exp;
      logic        zero;
      logic        uflow;
   } rec_t;

   rec_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   acc_cnt = 0;
   bit   verbose = 1'b1;

   norm_sched_80 #(.NREQ(NREQ), .EXP_W(EXP_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mant  (req_mant),
      .req_exp   (req_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lane  (out_lane),
      .out_mant  (out_mant),
      .out_exp   (out_exp),
      .out_zero  (out_zero),
      .out_uflow (out_uflow)
   );

   always #5 clk = ~clk;

   function automatic rec_t model(input int lane, input logic [79:0] m, input logic [15:0] e);
      rec_t r;
      int   lz;
      lz = 80;
      for (int b = 79; b >= 0; b--) begin
         if (m[b]) begin
            lz = 79 - b;
            break;
         end
      end
      r.lane = 2'(lane);
      if (lz == 80) begin
         r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uflow = 1'b0;
      end else if (lz <= int'(e)) begin
         r.mant = m << lz; r.exp = e - 16'(lz); r.zero = 1'b0; r.uflow = 1'b0;
      end else begin
         r.mant = m << e; r.exp = '0; r.zero = 1'b0; r.uflow = 1'b1;
      end
      return r;
   endfunction

   // monitor: legality of req_ready, scoreboard pop, then push of this cycle's acceptance
   always @(negedge clk) begin
      rec_t e;
      if (!rst) begin
         n_cmp++;
         if ((4'(req_ready & (req_ready - 4'd1)) != 4'd0) || ((req_ready & ~req_valid) != 4'd0)) begin
            n_err++;
            $display("FAIL ready_legal: req_ready=%b req_valid=%b", req_ready, req_valid);
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_result: lane=%0d mant=%h exp=%0d, none was due", out_lane, out_mant, out_exp);
            end else begin
               e = exp_q.pop_front();
               if (out_lane !== e.lane || out_mant !== e.mant || out_exp !== e.exp ||
                   out_zero !== e.zero || out_uflow !== e.uflow) begin
                  n_err++;
                  $display("FAIL scoreboard: got lane=%0d mant=%h exp=%0d z=%b u=%b, need lane=%0d mant=%h exp=%0d z=%b u=%b",
                           out_lane, out_mant, out_exp, out_zero, out_uflow, e.lane, e.mant, e.exp, e.zero, e.uflow);
               end else if (verbose) begin
                  $display("result lane=%0d mant=%h exp=%0d z=%b u=%b", out_lane, out_mant, out_exp, out_zero, out_uflow);
               end
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_q.push_back(model(i, req_mant[i*80 +: 80], req_exp[i*EXP_W +: EXP_W]));
               acc_cnt++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_lane(input int i, input logic [79:0] m, input logic [15:0] e);
      req_mant[i*80 +: 80]       = m;
      req_exp[i*EXP_W +: EXP_W] = e;
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = '0;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // caller sits just after a rising edge; returns just after the acceptance edge
   task automatic drive_one(input int lane, input logic [79:0] m, input logic [15:0] e);
      int t;
      set_lane(lane, m, e);
      req_valid = '0;
      req_valid[lane] = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_ready[lane] && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready[lane]) begin
         n_cmp++; n_err++;
         $display("FAIL drive_timeout: lane %0d never granted", lane);
      end
      @(posedge clk); #1;
      req_valid = '0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d results still outstanding, need 0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) set_lane(i, 80'hFF << i, 16'd40);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
      n_cmp++;
      if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b need 0000", req_ready); end
      n_cmp++;
      if (out_mant !== 80'd0 || out_exp !== 16'd0 || out_lane !== 2'd0 || out_zero !== 1'b0 || out_uflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got mant=%h exp=%0d lane=%0d z=%b u=%b need all 0", out_mant, out_exp, out_lane, out_zero, out_uflow);
      end
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b0;
   endtask

   task automatic test_single_lane();
      drive_one(2, 80'h1 << 63, 16'd100);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early: out_valid got %b need 0 one edge after accept", out_valid); end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_mant !== (80'h1 << 79) || out_exp !== 16'd84 || out_lane !== 2'd2 ||
          out_zero !== 1'b0 || out_uflow !== 1'b0) begin
         n_err++;
         $display("FAIL single_lane: got v=%b mant=%h exp=%0d lane=%0d z=%b u=%b need v=1 mant=%h exp=84 lane=2 z=0 u=0",
                  out_valid, out_mant, out_exp, out_lane, out_zero, out_uflow, 80'h1 << 79);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_uflow();
      logic [79:0] m_need;
      drive_one(1, 80'd0, 16'd77);
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_exp !== 16'd0 || out_mant !== 80'd0 || out_uflow !== 1'b0) begin
         n_err++;
         $display("FAIL zero_case: got v=%b z=%b exp=%0d mant=%h u=%b need v=1 z=1 exp=0 mant=0 u=0",
                  out_valid, out_zero, out_exp, out_mant, out_uflow);
      end
      @(posedge clk); #1;
      drive_one(3, 80'd1, 16'd5);
      @(negedge clk); @(negedge clk);
      m_need = 80'd32;
      n_cmp++;
      if (out_valid !== 1'b1 || out_mant !== m_need || out_exp !== 16'd0 || out_uflow !== 1'b1 || out_zero !== 1'b0) begin
         n_err++;
         $display("FAIL uflow_case: got v=%b mant=%h exp=%0d u=%b z=%b need v=1 mant=%h exp=0 u=1 z=0",
                  out_valid, out_mant, out_exp, out_uflow, out_zero, m_need);
      end
      @(posedge clk); #1;
      // lzc equal to exp is still the normal case
      drive_one(0, 80'd1, 16'd79);
      @(negedge clk); @(negedge clk);
      m_need = 80'h1 << 79;
      n_cmp++;
      if (out_valid !== 1'b1 || out_mant !== m_need || out_exp !== 16'd0 || out_uflow !== 1'b0 || out_zero !== 1'b0) begin
         n_err++;
         $display("FAIL lzc_eq_exp: got v=%b mant=%h exp=%0d u=%b z=%b need v=1 mant=%h exp=0 u=0 z=0",
                  out_valid, out_mant, out_exp, out_uflow, out_zero, m_need);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      logic [3:0] need;
      apply_reset();
      for (int i = 0; i < NREQ; i++) set_lane(i, 80'h1 << (10 * i + 3), 16'(20 + i));
      req_valid = '1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         need = 4'b0001 << (c % 4);
         n_cmp++;
         if (req_ready !== need) begin
            n_err++;
            $display("FAIL round_robin[%0d]: req_ready got %b need %b", c, req_ready, need);
         end
         @(posedge clk); #1;
      end
      req_valid = '0;
      wait_drain();
   endtask

   task automatic test_backpressure();
      int   base;
      bit   have_snap;
      logic [79:0] s_mant;
      logic [15:0] s_exp;
      logic [1:0]  s_lane;
      logic        s_zero, s_uflow;
      out_ready = 1'b0;
      set_lane(0, 80'h3 << 40, 16'd9);
      set_lane(1, 80'h5 << 70, 16'd300);
      set_lane(2, 80'h7, 16'd2);
      req_valid = 4'b0111;
      base = acc_cnt;
      have_snap = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (!have_snap) begin
               have_snap = 1'b1;
               s_mant = out_mant; s_exp = out_exp; s_lane = out_lane; s_zero = out_zero; s_uflow = out_uflow;
            end else begin
               n_cmp++;
               if (out_mant !== s_mant || out_exp !== s_exp || out_lane !== s_lane ||
                   out_zero !== s_zero || out_uflow !== s_uflow) begin
                  n_err++;
                  $display("FAIL stall_stable[%0d]: got mant=%h exp=%0d lane=%0d need mant=%h exp=%0d lane=%0d",
                           c, out_mant, out_exp, out_lane, s_mant, s_exp, s_lane);
               end
            end
         end
         @(posedge clk); #1;
      end
      req_valid = '0;
      n_cmp++;
      if (!have_snap) begin
         n_err++;
         $display("FAIL stall_out_valid: out_valid got 0 need 1 during stall");
      end
      n_cmp++;
      if (acc_cnt - base != 2) begin
         n_err++;
         $display("FAIL stall_accepts: got %0d need 2", acc_cnt - base);
      end
      wait_drain();
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) set_lane(i, 80'h9 << (5 * i), 16'(60 + i));
      req_valid = '1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid: got %b need 0", out_valid); end
      n_cmp++;
      if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midreset_first_grant: got %b need 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      wait_drain();
   endtask

   task automatic test_random();
      int base;
      int cyc;
      logic [95:0] r96;
      logic [79:0] m;
      logic [15:0] e;
      verbose = 1'b0;
      base = acc_cnt;
      cyc = 0;
      while (acc_cnt - base < 10000 && cyc < 60000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            r96 = {$urandom, $urandom, $urandom};
            m = r96[79:0] >> $urandom_range(0, 80);
            if ($urandom_range(0, 2) == 0) e = 16'($urandom_range(0, 85));
            else e = 16'($urandom);
            set_lane(i, m, e);
            req_valid[i] = ($urandom_range(0, 1) == 1);
         end
         @(posedge clk); #1;
         cyc++;
      end
      req_valid = '0;
      n_cmp++;
      if (acc_cnt - base < 10000) begin
         n_err++;
         $display("FAIL random_volume: accepted %0d need 10000", acc_cnt - base);
      end
      wait_drain();
      verbose = 1'b1;
   endtask

   initial begin
      req_mant = '0;
      req_exp  = '0;
      test_reset();
      test_single_lane();
      test_zero_uflow();
      test_round_robin();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/norm_sched_80.md
NORM_SCHED_80 -- requirements
Module: norm_sched_80

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesting lanes; legal values are 2..8.
REQ-002 The block SHALL have parameter EXP_W, default 16, giving the exponent width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-lane request valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-lane accept; at most one bit is high per cycle.
REQ-007 The block SHALL have port req_mant, input, NREQ*80 bits: lane i mantissa in bits [80i+79:80i].
REQ-008 The block SHALL have port req_exp, input, NREQ*EXP_W bits: lane i biased exponent, unsigned.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port out_lane, output, clog2(NREQ) bits: the originating lane of the result.
REQ-012 The block SHALL have port out_mant, output, 80 bits: the normalized mantissa.
REQ-013 The block SHALL have port out_exp, output, EXP_W bits: the adjusted exponent.
REQ-014 The block SHALL have port out_zero, output, 1 bit: the input mantissa was all zero.
REQ-015 The block SHALL have port out_uflow, output, 1 bit: the shift was limited by the exponent (denormal result).

Function
REQ-016 The block SHALL share one 80-bit leading-zero counter and one left shifter among NREQ lanes through a 2-stage valid/ready pipeline: S1 (arbitrate + operand register) and S2 (count + shift + result register).
REQ-017 The transfer rule SHALL be: a lane transfers when req_valid[i] && req_ready[i]; a result transfers when out_valid && out_ready.
REQ-018 Stage enables SHALL be: s2_en = !out_valid || out_ready; s1_en = !s1_valid || s2_en; no grant is issued when s1_en is 0.
REQ-019 Arbitration SHALL be round-robin: the search starts at pointer ptr; the first valid lane at or after ptr (mod NREQ) is granted.
REQ-020 After a grant to lane k, ptr SHALL become (k+1) mod NREQ; without a grant, ptr SHALL hold.
REQ-021 req_ready SHALL be combinational from req_valid, ptr and s1_en; req_ready[i] never asserts when req_valid[i] is 0.
REQ-022 Latency SHALL be 2 cycles: with no backpressure, out_valid rises on the second rising edge after acceptance; throughput is 1 result per cycle.
REQ-023 Count SHALL be lzc = number of leading zeros of the S1 mantissa (0..80); lzc = 80 for an all-zero mantissa.
REQ-024 Zero case: if lzc = 80, the result SHALL be out_mant = 0, out_exp = 0, out_zero = 1, out_uflow = 0.
REQ-025 Normal case: if lzc <= exp, the result SHALL be out_mant = mant << lzc, out_exp = exp - lzc, out_uflow = 0.
REQ-026 Underflow case: if lzc > exp, the result SHALL be out_mant = mant << exp, out_exp = 0, out_uflow = 1.
REQ-027 Arithmetic SHALL be unsigned; the lzc vs exp comparison is done at EXP_W width with lzc zero-extended.
REQ-028 Stall behaviour: while out_valid && !out_ready, all outputs SHALL hold stable and S1 holds if occupied.
REQ-029 Simultaneous events SHALL complete in the same edge: an output drain, an S1->S2 move and a new grant.
REQ-030 A lane dropping req_valid without a grant SHALL be legal and SHALL leave no state behind.

Reset
REQ-031 While rst = 1 at a clock edge: out_valid, s1_valid and ptr SHALL clear to 0; out_mant, out_exp, out_lane, out_zero and out_uflow SHALL clear to 0; req_ready is 0 in the reset cycle.
REQ-032 Reset asserted mid-operation SHALL discard in-flight operands without producing output; the first grant is possible in the cycle after rst deasserts.

Structure
REQ-033 The shared package SHALL hold: the mantissa width constant (80), the LZC width constant (7), and the result struct/field widths (lane, mant, exp, zero, uflow).
REQ-034 The 80-bit leading-zero counter SHALL be instantiated once as sub-module lza_80 inside S2; the arbiter and shifter remain in this block.

Verification
REQ-035 Single lane: lane 2 sends mant = 80'h0000_8000..0 (bit 63 set, lzc = 16), exp = 100 -> after 2 cycles out_mant bit 79 set, out_exp = 84, out_lane = 2, flags = 0.
REQ-036 Round-robin: all 4 lanes held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one accept per cycle.
REQ-037 Zero and underflow: mant = 0 gives out_zero = 1 and out_exp = 0; mant = 1 (lzc = 79) with exp = 5 gives out_mant = 1 << 5, out_exp = 0, out_uflow = 1.
REQ-038 Backpressure: out_ready = 0 for 5 cycles with 3 lanes valid -> exactly 2 operands accepted, outputs stable; results drain in grant order after release, with none lost or duplicated.
REQ-039 Reset mid-stream: assert rst with both stages full -> out_valid = 0 next cycle and ptr = 0; the first post-reset grant goes to lane 0 when all lanes are valid.
REQ-040 Random: 10k mixed operands with random out_ready -> results match the reference model per REQ-024..REQ-026 and per-lane ordering is preserved.
